// File: rtl/mdu_ctrl_pkg.sv
// Shared types and constants for the multiply/divide sequencer.
// Op encodings, FSM states and the HI/LO write bus layout.
package mdu_ctrl_pkg;

    typedef enum logic [1:0] {
        MDU_OP_MULT  = 2'b00,
        MDU_OP_MULTU = 2'b01,
        MDU_OP_DIV   = 2'b10,
        MDU_OP_DIVU  = 2'b11
    } mdu_op_e;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_MUL     = 3'd1,
        ST_DIV_RUN = 3'd2,
        ST_DIV_FIX = 3'd3,
        ST_DONE    = 3'd4
    } mdu_state_e;

    localparam int MDU_TO_HILO_WD = 66;

    typedef struct packed {
        logic        hi_we;
        logic        lo_we;
        logic [31:0] hi_wdata;
        logic [31:0] lo_wdata;
    } mdu_hilo_t;

    // Magnitude of a value, treating it as two's complement only when signed.
    function automatic logic [31:0] mag32(input logic [31:0] v,
                                          input logic        sgn);
        return (sgn && v[31]) ? (32'd0 - v) : v;
    endfunction

endpackage

// File: rtl/mdu_ctrl_div_step.sv
// One restoring-divide iteration: shift in a dividend bit,
// trial-subtract the divisor, keep the difference when it does not borrow.
module mdu_ctrl_div_step (
    input  logic [31:0] rem_i,
    input  logic        bit_i,
    input  logic [31:0] dvs_i,
    output logic [31:0] rem_o,
    output logic        q_o
);

    logic [32:0] part;
    logic [32:0] diff;

    // A set top bit of the partial remainder already exceeds any divisor,
    // otherwise the sign of the 33-bit difference is the borrow.
    always_comb begin
        part  = {rem_i, bit_i};
        diff  = part - {1'b0, dvs_i};
        q_o   = part[32] | ~diff[32];
        rem_o = q_o ? diff[31:0] : part[31:0];
    end

endmodule

// File: rtl/mdu_ctrl.sv
// Multiply/divide sequencer for EX: 1-cycle product or 32-step divide,
// pipeline stall request and HI/LO write-port arbitration with mthi/mtlo.
module mdu_ctrl
    import mdu_ctrl_pkg::*;
#(
    parameter int DIV_ITERS = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] src1,
    input  logic [31:0] src2,
    input  logic        flush,
    input  logic        mt_we,
    input  logic        mt_sel,
    input  logic [31:0] mt_wdata,
    output logic        stallreq,
    output logic        busy,
    output logic        hi_we,
    output logic        lo_we,
    output logic [31:0] hi_wdata,
    output logic [31:0] lo_wdata
);

    localparam int CW = $clog2(DIV_ITERS);
    localparam logic [CW-1:0] CNT_LAST = CW'(DIV_ITERS - 1);

    mdu_state_e    state_q, state_d;
    logic          sgn_q, sgn_d;
    logic [31:0]   src1_q, src1_d;
    logic [31:0]   src2_q, src2_d;
    logic [31:0]   rem_q, rem_d;
    logic [31:0]   quo_q, quo_d;
    logic [31:0]   dvs_q, dvs_d;
    logic [31:0]   hi_q, hi_d;
    logic [31:0]   lo_q, lo_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic signed [32:0] mul_a;
    logic signed [32:0] mul_b;
    logic [63:0]        prod;
    logic [31:0]        step_rem;
    logic               step_q;
    logic               q_neg;
    logic               r_neg;
    mdu_hilo_t          hilo;

    mdu_ctrl_div_step u_step (
        .rem_i (rem_q),
        .bit_i (quo_q[31]),
        .dvs_i (dvs_q),
        .rem_o (step_rem),
        .q_o   (step_q)
    );

    // 33x33 signed multiply; unsigned ops zero-extend into the 33rd bit.
    always_comb begin
        mul_a = {sgn_q & src1_q[31], src1_q};
        mul_b = {sgn_q & src2_q[31], src2_q};
        prod  = 64'(mul_a * mul_b);
        q_neg = sgn_q & (src1_q[31] ^ src2_q[31]);
        r_neg = sgn_q & src1_q[31];
    end

    // State, operand and result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            sgn_q   <= 1'b0;
            src1_q  <= '0;
            src2_q  <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            dvs_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            sgn_q   <= sgn_d;
            src1_q  <= src1_d;
            src2_q  <= src2_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            dvs_q   <= dvs_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state and datapath sequencing; flush always returns to IDLE.
    always_comb begin
        state_d = state_q;
        sgn_d   = sgn_q;
        src1_d  = src1_q;
        src2_d  = src2_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        dvs_d   = dvs_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start && !flush) begin
                    sgn_d  = ~op[0];
                    src1_d = src1;
                    src2_d = src2;
                    cnt_d  = '0;
                    rem_d  = '0;
                    quo_d  = mag32(src1, ~op[0]);
                    dvs_d  = mag32(src2, ~op[0]);
                    if (op == MDU_OP_MULT || op == MDU_OP_MULTU) begin
                        state_d = ST_MUL;
                    end else if (src2 == 32'd0) begin
                        state_d = ST_DIV_FIX;
                    end else begin
                        state_d = ST_DIV_RUN;
                    end
                end
            end
            ST_MUL: begin
                {hi_d, lo_d} = prod;
                state_d      = ST_DONE;
            end
            ST_DIV_RUN: begin
                rem_d = step_rem;
                quo_d = {quo_q[30:0], step_q};
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    state_d = ST_DIV_FIX;
                end
            end
            ST_DIV_FIX: begin
                if (src2_q == 32'd0) begin
                    lo_d = 32'hFFFF_FFFF;
                    hi_d = src1_q;
                end else if (sgn_q && src1_q == 32'h8000_0000
                             && src2_q == 32'hFFFF_FFFF) begin
                    lo_d = 32'h8000_0000;
                    hi_d = 32'd0;
                end else begin
                    lo_d = q_neg ? (32'd0 - quo_q) : quo_q;
                    hi_d = r_neg ? (32'd0 - rem_q) : rem_q;
                end
                state_d = ST_DONE;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        if (flush) begin
            state_d = ST_IDLE;
        end
    end

    // HI/LO port: the result owns both registers in DONE, else mt passes.
    always_comb begin
        hilo = '0;
        if (state_q == ST_DONE && !flush) begin
            hilo.hi_we    = 1'b1;
            hilo.lo_we    = 1'b1;
            hilo.hi_wdata = hi_q;
            hilo.lo_wdata = lo_q;
        end else if (mt_we) begin
            if (mt_sel) begin
                hilo.hi_we    = 1'b1;
                hilo.hi_wdata = mt_wdata;
            end else begin
                hilo.lo_we    = 1'b1;
                hilo.lo_wdata = mt_wdata;
            end
        end
        if (rst) begin
            hilo = '0;
        end
    end

    // Stall the front of the pipe from issue until the result cycle.
    always_comb begin
        busy     = !rst && (state_q != ST_IDLE);
        stallreq = !rst && !flush
                   && ((state_q == ST_IDLE && start)
                       || (busy && state_q != ST_DONE));
        hi_we    = hilo.hi_we;
        lo_we    = hilo.lo_we;
        hi_wdata = hilo.hi_wdata;
        lo_wdata = hilo.lo_wdata;
    end

endmodule

// File: tb/tb_mdu_ctrl.sv
// Scoreboard bench for mdu_ctrl: directed cases then random ops,
// expected HI/LO writes queued at issue and popped by a monitor.
module tb_mdu_ctrl;

    logic        clk;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [31:0] src1;
    logic [31:0] src2;
    logic        flush;
    logic        mt_we;
    logic        mt_sel;
    logic [31:0] mt_wdata;
    logic        stallreq;
    logic        busy;
    logic        hi_we;
    logic        lo_we;
    logic [31:0] hi_wdata;
    logic [31:0] lo_wdata;

    int tests;
    int fails;
    int cyc;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          cyc;
    } res_t;

    typedef struct {
        logic        sel;
        logic [31:0] d;
    } mt_t;

    res_t rq[$];
    mt_t  mq[$];

    mdu_ctrl dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .op       (op),
        .src1     (src1),
        .src2     (src2),
        .flush    (flush),
        .mt_we    (mt_we),
        .mt_sel   (mt_sel),
        .mt_wdata (mt_wdata),
        .stallreq (stallreq),
        .busy     (busy),
        .hi_we    (hi_we),
        .lo_we    (lo_we),
        .hi_wdata (hi_wdata),
        .lo_wdata (lo_wdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name,
                         input logic [63:0] act,
                         input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: MIPS mult/div semantics from plain integer arithmetic.
    function automatic void model(input logic [1:0] o,
                                  input logic [31:0] a,
                                  input logic [31:0] b,
                                  output logic [31:0] hi,
                                  output logic [31:0] lo);
        logic [63:0] p;
        p = 64'd0;
        case (o)
            2'b00: begin
                p = longint'($signed(a)) * longint'($signed(b));
                {hi, lo} = p;
            end
            2'b01: begin
                p = {32'd0, a} * {32'd0, b};
                {hi, lo} = p;
            end
            2'b10: begin
                if (b == 0) begin
                    lo = 32'hFFFF_FFFF;
                    hi = a;
                end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    lo = 32'h8000_0000;
                    hi = 32'd0;
                end else begin
                    lo = 32'($signed(a) / $signed(b));
                    hi = 32'($signed(a) % $signed(b));
                end
            end
            default: begin
                if (b == 0) begin
                    lo = 32'hFFFF_FFFF;
                    hi = a;
                end else begin
                    lo = a / b;
                    hi = a % b;
                end
            end
        endcase
    endfunction

    // Called right after a posedge; issues in that cycle (cycle 0).
    // fl_k / mt_k: cycle of flush / mt write, negative for none.
    task automatic issue(input logic [1:0] o,
                         input logic [31:0] a,
                         input logic [31:0] b,
                         input int fl_k,
                         input int mt_k,
                         input logic ms,
                         input logic [31:0] md);
        int          lat;
        int          last;
        logic [31:0] eh;
        logic [31:0] el;
        logic        stall_bad;
        logic        busy_bad;
        logic        es;
        logic        eb;
        res_t        r;
        mt_t         m;
        lat  = (o[1] == 1'b0 || b == 0) ? 2 : 34;
        last = (fl_k >= 0) ? fl_k + 1 : lat;
        model(o, a, b, eh, el);
        if (fl_k < 0) begin
            r.hi  = eh;
            r.lo  = el;
            r.cyc = cyc + lat;
            rq.push_back(r);
        end
        stall_bad = 1'b0;
        busy_bad  = 1'b0;
        for (int k = 0; k <= last; k++) begin
            if (k > 0) begin
                @(posedge clk);
                #1;
            end
            start    = (k == 0);
            op       = (k == 0) ? o : 2'($urandom);
            src1     = (k == 0) ? a : $urandom;
            src2     = (k == 0) ? b : $urandom;
            flush    = (k == fl_k);
            mt_we    = (k == mt_k);
            mt_sel   = ms;
            mt_wdata = md;
            if (k == mt_k && k != lat) begin
                m.sel = ms;
                m.d   = md;
                mq.push_back(m);
            end
            @(negedge clk);
            es = (fl_k >= 0) ? (k < fl_k) : (k < lat);
            eb = (k > 0) && ((fl_k < 0) || (k <= fl_k));
            if (stallreq !== es) stall_bad = 1'b1;
            if (busy !== eb) busy_bad = 1'b1;
        end
        @(posedge clk);
        #1;
        start = 1'b0;
        flush = 1'b0;
        mt_we = 1'b0;
        check("stall_window", {63'd0, stall_bad}, 64'd0);
        check("busy_window", {63'd0, busy_bad}, 64'd0);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'd0;
            1: return 32'd1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    // Monitor: every write the DUT presents must match the queue head.
    always @(negedge clk) begin
        if (!rst) begin
            if (hi_we && lo_we) begin
                if (rq.size() == 0) begin
                    check("unexpected_result", {hi_wdata, lo_wdata}, 64'd0);
                end else begin
                    res_t r;
                    r = rq.pop_front();
                    check("result", {hi_wdata, lo_wdata}, {r.hi, r.lo});
                    check("result_cycle", 64'(cyc), 64'(r.cyc));
                end
            end else if (hi_we || lo_we) begin
                if (mq.size() == 0) begin
                    check("unexpected_mt", {31'd0, hi_we, hi_wdata | lo_wdata},
                          64'd0);
                end else begin
                    mt_t m;
                    m = mq.pop_front();
                    check("mt_write",
                          {31'd0, hi_we, hi_we ? hi_wdata : lo_wdata},
                          {31'd0, m.sel, m.d});
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0]  o;
        logic [31:0] a;
        logic [31:0] b;
        int          lat;
        int          fk;
        int          mk;
        tests    = 0;
        fails    = 0;
        cyc      = 0;
        rst      = 1'b1;
        start    = 1'b0;
        op       = 2'b00;
        src1     = 32'd0;
        src2     = 32'd0;
        flush    = 1'b0;
        mt_we    = 1'b0;
        mt_sel   = 1'b0;
        mt_wdata = 32'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_outputs",
              {hi_we, lo_we, stallreq, busy, hi_wdata, lo_wdata}, 68'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        issue(2'b01, 32'hFFFF_FFFF, 32'd2, -1, -1, 1'b0, 32'd0);
        issue(2'b10, 32'hFFFF_FFF9, 32'd2, -1, -1, 1'b0, 32'd0);
        issue(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, -1, -1, 1'b0, 32'd0);
        issue(2'b11, 32'd5, 32'd0, -1, -1, 1'b0, 32'd0);
        issue(2'b11, 32'd100, 32'd7, 10, -1, 1'b0, 32'd0);
        issue(2'b00, 32'd3, 32'd4, -1, 2, 1'b1, 32'h1234);
        issue(2'b00, 32'd3, 32'd4, -1, 1, 1'b1, 32'h1234);
        issue(2'b10, 32'd7, 32'hFFFF_FFFE, -1, 20, 1'b0, 32'hBEEF);

        start = 1'b1;
        flush = 1'b1;
        op    = 2'b10;
        src2  = 32'd3;
        @(posedge clk);
        #1;
        start = 1'b0;
        flush = 1'b0;
        @(negedge clk);
        check("start_with_flush", {63'd0, busy}, 64'd0);
        @(posedge clk);
        #1;

        for (int i = 0; i < 40; i++) begin
            o   = 2'($urandom);
            a   = pick();
            b   = pick();
            lat = (o[1] == 1'b0 || b == 0) ? 2 : 34;
            fk  = -1;
            mk  = -1;
            if ($urandom_range(0, 7) == 0) begin
                fk = $urandom_range(1, lat - 1);
            end else if ($urandom_range(0, 3) == 0) begin
                mk = $urandom_range(0, lat);
            end
            issue(o, a, b, fk, mk, 1'($urandom), $urandom);
        end

        repeat (3) @(posedge clk);
        check("result_queue_empty", 64'(rq.size()), 64'd0);
        check("mt_queue_empty", 64'(mq.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
